// File: rtl/trail_pkg.sv
// trail_pkg: constants and sequencer state encoding shared by the
// trail scheduler and the VGA renderer.
package trail_pkg;

  localparam int TRAIL_N    = 28;
  localparam int LIFE_MAX   = 10;
  localparam int TRAIL_SIZE = 8;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int L_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DECAY,
    SPAWN,
    CLEAR
  } trail_state_t;

endpackage

// File: rtl/trail_scheduler.sv
// trail_scheduler: ages, spawns and clears the player trail table
// once per frame during vertical blanking.
module trail_scheduler
  import trail_pkg::*;
#(
  parameter int TRAIL_N     = trail_pkg::TRAIL_N,
  parameter int LIFE_MAX    = trail_pkg::LIFE_MAX,
  parameter int TRAIL_SPEED = 4,
  parameter int SPAWN_DIV   = 2,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int TRAIL_SIZE  = trail_pkg::TRAIL_SIZE,
  parameter int LOWER_BOUND = 460
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic [1:0]                    gamemode,
  input  logic [8:0]                    player_y,
  output logic [TRAIL_N-1:0][X_W-1:0]   trail_x,
  output logic [TRAIL_N-1:0][Y_W-1:0]   trail_y,
  output logic [TRAIL_N-1:0][L_W-1:0]   trail_life,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IW = $clog2(TRAIL_N);
  localparam int CW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  localparam logic [IW-1:0]  LAST     = IW'(TRAIL_N - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SPAWN_DIV - 1);
  localparam logic [X_W-1:0] SPEED    = X_W'(TRAIL_SPEED);
  localparam logic [X_W-1:0] SPAWN_X  = X_W'(PLAYER_X - TRAIL_SIZE);
  localparam logic [L_W-1:0] LIFE_NEW = L_W'(LIFE_MAX);
  localparam logic [9:0]     Y_OFS    = 10'((PLAYER_SIZE - TRAIL_SIZE) / 2);
  localparam logic [9:0]     Y_LIM    = 10'(LOWER_BOUND - TRAIL_SIZE);

  trail_state_t state, state_d;

  logic [IW-1:0]  idx, idx_d;
  logic [IW-1:0]  wr_ptr, wr_ptr_d;
  logic [CW-1:0]  spawn_cnt, spawn_cnt_d;

  logic           we;
  logic [IW-1:0]  w_idx;
  logic [X_W-1:0] w_x;
  logic [Y_W-1:0] w_y;
  logic [L_W-1:0] w_l;

  logic [9:0]     y_sum;
  logic [Y_W-1:0] spawn_y;
  logic [X_W+L_W-1:0] aged;

  // Particles hitting the left edge die instead of wrapping.
  function automatic logic [X_W+L_W-1:0] age(
    input logic [X_W-1:0] x,
    input logic [L_W-1:0] l
  );
    logic [X_W+L_W-1:0] r;
    r = {x, l};
    if (l != '0) begin
      if (x < SPEED) r = '0;
      else           r = {x - SPEED, l - L_W'(1)};
    end
    return r;
  endfunction

  assign aged    = age(trail_x[idx], trail_life[idx]);
  assign y_sum   = {1'b0, player_y} + Y_OFS;
  assign spawn_y = (y_sum > Y_LIM) ? Y_LIM[Y_W-1:0] : y_sum[Y_W-1:0];

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    wr_ptr_d    = wr_ptr;
    spawn_cnt_d = spawn_cnt;
    we          = 1'b0;
    w_idx       = idx;
    w_x         = '0;
    w_y         = '0;
    w_l         = '0;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          unique case (1'b1)
            (gamemode == 2'b01): begin
              state_d = DECAY;
              idx_d   = '0;
            end
            (gamemode == 2'b00): begin
              state_d     = CLEAR;
              idx_d       = '0;
              wr_ptr_d    = '0;
              spawn_cnt_d = '0;
            end
            default: ;
          endcase
        end
      end
      DECAY: begin
        we  = 1'b1;
        w_y = trail_y[idx];
        {w_x, w_l} = aged;
        if (idx == LAST) begin
          idx_d       = '0;
          state_d     = (spawn_cnt == CNT_LAST) ? SPAWN : IDLE;
          spawn_cnt_d = (spawn_cnt == CNT_LAST) ? '0
                                                : spawn_cnt + CW'(1);
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      SPAWN: begin
        we       = 1'b1;
        w_idx    = wr_ptr;
        w_x      = SPAWN_X;
        w_y      = spawn_y;
        w_l      = LIFE_NEW;
        wr_ptr_d = (wr_ptr == LAST) ? '0 : wr_ptr + IW'(1);
        state_d  = IDLE;
      end
      CLEAR: begin
        we = 1'b1;
        if (idx == LAST) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wr_ptr     <= '0;
      spawn_cnt  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      trail_x    <= '0;
      trail_y    <= '0;
      trail_life <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      wr_ptr    <= wr_ptr_d;
      spawn_cnt <= spawn_cnt_d;
      busy      <= (state_d != IDLE);
      overrun   <= frame_tick && (state != IDLE);
      if (we) begin
        trail_x[w_idx]    <= w_x;
        trail_y[w_idx]    <= w_y;
        trail_life[w_idx] <= w_l;
      end
    end
  end

endmodule
